// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between the fetch (IF) and memory (MEM)
// stages with fixed MEM-over-IF priority, programmable wait states and byte-lane steering.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        ram_en,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic G_IF  = 1'b0;
  localparam logic G_MEM = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_enables = 4'b0001 << lane;
      SZ_HALF: lane_enables = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: replicate = {4{data[7:0]}};
      SZ_HALF: replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lane,
                                          input logic [31:0] data);
    case (size)
      SZ_BYTE: extract = {24'd0, data[{lane, 3'b000} +: 8]};
      SZ_HALF: extract = {16'd0, (lane[1] ? data[31:16] : data[15:0])};
      default: extract = data;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [3:0]       ram_be_q, ram_be_d;
  logic [31:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_wdata_q, ram_wdata_d;
  logic             if_ack_q, if_ack_d;
  logic             mem_ack_q, mem_ack_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic [31:0]      resp;

  always_comb begin
    // NOTE: every *_d gets its default before the case so no path can infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    lane_d      = lane_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    resp        = '0;

    case (state_q)
      S_IDLE: begin
        // MEM wins a tie: it holds the older instruction.
        if (mem_req || if_req) begin
          grant_d     = mem_req ? G_MEM : G_IF;
          we_d        = mem_req & mem_we;
          size_d      = mem_req ? mem_size : SZ_WORD;
          lane_d      = mem_req ? mem_addr[1:0] : if_addr[1:0];
          ram_addr_d  = {(mem_req ? mem_addr[31:2] : if_addr[31:2]), 2'b00};
          ram_be_d    = lane_enables(size_d, lane_d);
          ram_wdata_d = mem_req ? replicate(mem_size, mem_wdata) : '0;
          ram_en_d    = 1'b1;
          ram_we_d    = we_d;
          cnt_d       = CNT_LOAD;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          resp    = we_q ? '0 : extract(size_q, lane_q, ram_rdata);
          state_d = S_RESP;
          if (grant_q == G_MEM) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = resp;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = resp;
          end
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          ram_en_d = 1'b1;
          ram_we_d = we_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including the held RAM-side values.
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= G_IF;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = mem_req & ~mem_ack_q;

endmodule
